// File: rtl/timer_pkg.sv
// timer_pkg: shared constants for the 8-bit APB timer.
//   Address map of the four registers (TDR, TCR, TSR, TCNT).
//   Bit indices inside TCR and TSR.
//   Write mask for TCR: the reserved bits 6 and 3:2 are never stored.
package timer_pkg;

    localparam logic [7:0] ADDR_TDR  = 8'h00;
    localparam logic [7:0] ADDR_TCR  = 8'h01;
    localparam logic [7:0] ADDR_TSR  = 8'h02;
    localparam logic [7:0] ADDR_TCNT = 8'h03;

    localparam int TCR_LOAD   = 7;
    localparam int TCR_DOWN   = 5;
    localparam int TCR_EN     = 4;
    localparam int TCR_CKS_HI = 1;
    localparam int TCR_CKS_LO = 0;

    localparam int TSR_OVF = 0;
    localparam int TSR_UDF = 1;

    localparam logic [7:0] TCR_WMASK = 8'hB3;

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running 4-bit divider and tick select.
//   pclk    in   system clock
//   presetn in   asynchronous active-low reset (divider returns to 0)
//   cks     in   2-bit rate select: tick every 2, 4, 8 or 16 pclk
//   tick    out  one-pclk pulse when the low cks+1 divider bits are all ones
module timer_prescaler (
    input  logic       pclk,
    input  logic       presetn,
    input  logic [1:0] cks,
    output logic       tick
);

    logic [3:0] div;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            div <= 4'd0;
        end else begin
            div <= div + 4'd1;
        end
    end

    always_comb begin
        tick = 1'b0;
        unique case (cks)
            2'b00:   tick = div[0];
            2'b01:   tick = &div[1:0];
            2'b10:   tick = &div[2:0];
            default: tick = &div;
        endcase
    end

endmodule

// File: rtl/timer_8bit.sv
// timer_8bit: 8-bit up/down timer with a zero-wait-state APB slave.
//   pclk, presetn         clock and asynchronous active-low reset
//   psel, penable, pwrite APB control
//   paddr, pwdata         APB address and write data (8 bits each)
//   prdata                read data, combinational during the access phase, 0 otherwise
//   pready                high during the access phase
//   pslverr               always 0
// Registers: TDR reload value, TCR control, TSR sticky flags (write 0 to clear),
// TCNT counter (read-only).
module timer_8bit
    import timer_pkg::*;
(
    input  logic       pclk,
    input  logic       presetn,
    input  logic       psel,
    input  logic       penable,
    input  logic       pwrite,
    input  logic [7:0] paddr,
    input  logic [7:0] pwdata,
    output logic [7:0] prdata,
    output logic       pready,
    output logic       pslverr
);

    logic [7:0] tdr;
    logic [7:0] tcr;
    logic [7:0] tcnt;
    logic [1:0] tsr;

    logic       tick;
    logic       wr_en;
    logic       rd_en;
    logic       count_en;
    logic [1:0] flag_set;

    assign wr_en = psel & penable & pwrite;
    assign rd_en = psel & penable & ~pwrite;

    assign pready  = psel & penable;
    assign pslverr = 1'b0;

    timer_prescaler u_prescaler (
        .pclk    (pclk),
        .presetn (presetn),
        .cks     (tcr[TCR_CKS_HI:TCR_CKS_LO]),
        .tick    (tick)
    );

    // LOAD inhibits counting; it is handled ahead of the count in the TCNT process.
    assign count_en = tick & tcr[TCR_EN] & ~tcr[TCR_LOAD];

    always_comb begin
        flag_set          = 2'b00;
        flag_set[TSR_OVF] = count_en & ~tcr[TCR_DOWN] & (tcnt == 8'hFF);
        flag_set[TSR_UDF] = count_en &  tcr[TCR_DOWN] & (tcnt == 8'h00);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tdr <= 8'h00;
            tcr <= 8'h00;
        end else if (wr_en) begin
            if (paddr == ADDR_TDR) tdr <= pwdata;
            if (paddr == ADDR_TCR) tcr <= pwdata & TCR_WMASK;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tcnt <= 8'h00;
        end else if (tcr[TCR_LOAD]) begin
            tcnt <= tdr;
        end else if (count_en) begin
            tcnt <= tcr[TCR_DOWN] ? tcnt - 8'd1 : tcnt + 8'd1;
        end
    end

    // Write-0-to-clear; a hardware set in the same cycle is OR'd in last so it wins.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            tsr <= 2'b00;
        end else if (wr_en && (paddr == ADDR_TSR)) begin
            tsr <= (tsr & pwdata[1:0]) | flag_set;
        end else begin
            tsr <= tsr | flag_set;
        end
    end

    always_comb begin
        prdata = 8'h00;
        if (rd_en) begin
            unique case (paddr)
                ADDR_TDR:  prdata = tdr;
                ADDR_TCR:  prdata = tcr;
                ADDR_TSR:  prdata = {6'b0, tsr};
                ADDR_TCNT: prdata = tcnt;
                default:   prdata = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_timer_8bit.sv
// tb_timer_8bit: self-checking bench for timer_8bit.
module tb_timer_8bit;

    logic       pclk;
    logic       presetn;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        bit         wr;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        logic [7:0] exp;
        string      name;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb_q[$];

    // Reference prescaler phase, used only to place writes on a known tick cycle.
    logic [3:0] mdiv;

    timer_8bit dut (
        .pclk    (pclk),
        .presetn (presetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) mdiv <= 4'd0;
        else          mdiv <= mdiv + 4'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", nm, act, exp);
        end
    endtask

    task automatic check_range(input string nm, input logic [7:0] act,
                               input logic [7:0] lo, input logic [7:0] hi);
        n_checks++;
        if ((act < lo) || (act > hi) || $isunknown(act)) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h..%02h", nm, act, lo, hi);
        end
    endtask

    task automatic apb_wr(input logic [7:0] a, input logic [7:0] d);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd_val(input logic [7:0] a, output logic [7:0] v);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        #3;
        v = prdata;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // Expected value is queued at setup and consumed when the access phase is sampled.
    task automatic apb_rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        sb_t e;
        sb_q.push_back('{exp, nm});
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge pclk); #1;
        penable = 1'b1;
        #3;
        e = sb_q.pop_front();
        check(e.name, prdata, e.exp);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic sync_to_13();
        for (int i = 0; i < 40; i++) begin
            if (mdiv == 4'd13) break;
            @(posedge pclk); #1;
        end
        check("tick_sync", {4'h0, mdiv}, 8'h0D);
    endtask

    initial begin
        logic [7:0] v;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00; pwdata = 8'h00;
        presetn = 1'b0;
        repeat (3) @(posedge pclk);
        #1 presetn = 1'b1;

        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'h00, "rst_tdr"});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h00, "rst_tcr"});
        vecs.push_back('{1'b0, 8'h02, 8'h00, 8'h00, "rst_tsr"});
        vecs.push_back('{1'b0, 8'h03, 8'h00, 8'h00, "rst_tcnt"});
        vecs.push_back('{1'b0, 8'h04, 8'h00, 8'h00, "unmapped_rd"});
        vecs.push_back('{1'b1, 8'h00, 8'hA5, 8'h00, ""});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'hA5, "tdr_rw"});
        vecs.push_back('{1'b1, 8'h01, 8'hFF, 8'h00, ""});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 8'hB3, "tcr_reserved"});
        vecs.push_back('{1'b0, 8'h03, 8'h00, 8'hA5, "load_tcnt"});
        vecs.push_back('{1'b1, 8'h01, 8'h00, 8'h00, ""});
        vecs.push_back('{1'b1, 8'h03, 8'h12, 8'h00, ""});
        vecs.push_back('{1'b0, 8'h03, 8'h00, 8'hA5, "tcnt_readonly"});
        vecs.push_back('{1'b1, 8'h07, 8'h55, 8'h00, ""});
        vecs.push_back('{1'b0, 8'h00, 8'h00, 8'hA5, "unmapped_wr_tdr"});
        vecs.push_back('{1'b0, 8'h07, 8'h00, 8'h00, "unmapped_rd2"});
        vecs.push_back('{1'b1, 8'h02, 8'hFF, 8'h00, ""});
        vecs.push_back('{1'b0, 8'h02, 8'h00, 8'h00, "tsr_write_ones"});
        vecs.push_back('{1'b0, 8'h01, 8'h00, 8'h00, "tcr_cleared"});

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].wr) apb_wr(vecs[i].addr, vecs[i].data);
            else            apb_rd(vecs[i].addr, vecs[i].exp, vecs[i].name);
        end

        // Bus-level behaviour: prdata 0 outside the access phase, pready/pslverr.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h00;
        #3;
        check("prdata_setup_phase", prdata, 8'h00);
        check("pready_setup_phase", {7'b0, pready}, 8'h00);
        @(posedge pclk); #1;
        penable = 1'b1;
        #3;
        check("pready_access", {7'b0, pready}, 8'h01);
        check("pslverr", {7'b0, pslverr}, 8'h00);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;

        // Count down from 0xFF for ~400 pclk: no underflow.
        apb_wr(8'h00, 8'hFF);
        apb_wr(8'h01, 8'h80);
        apb_wr(8'h01, 8'h30);
        repeat (400) @(posedge pclk);
        apb_rd(8'h02, 8'h00, "no_udf_tsr");
        apb_rd_val(8'h03, v);
        check_range("no_udf_tcnt", v, 8'h30, 8'h40);

        // Reset mid-count.
        @(posedge pclk); #3;
        presetn = 1'b0;
        #500;
        presetn = 1'b1;
        apb_rd(8'h02, 8'h00, "midrst_tsr");
        apb_rd(8'h03, 8'h00, "midrst_tcnt");
        apb_rd(8'h01, 8'h00, "midrst_tcr");
        apb_rd(8'h00, 8'h00, "midrst_tdr");
        apb_wr(8'h01, 8'h30);
        repeat (20) @(posedge pclk);
        apb_rd(8'h02, 8'h02, "udf_set");

        // Flag clearing: ones keep, zeros clear.
        apb_wr(8'h02, 8'h03);
        apb_rd(8'h02, 8'h02, "tsr_w1_keeps");
        apb_wr(8'h02, 8'h00);
        apb_rd(8'h02, 8'h00, "tsr_w0_clears");
        apb_wr(8'h01, 8'h00);

        // Overflow with CKS=11.
        apb_wr(8'h00, 8'hFE);
        apb_wr(8'h01, 8'h80);
        apb_wr(8'h01, 8'h13);
        apb_rd(8'h02, 8'h00, "ovf_not_yet");
        repeat (40) @(posedge pclk);
        apb_rd(8'h02, 8'h01, "ovf_set");
        apb_rd_val(8'h03, v);
        check_range("ovf_tcnt_wrapped", v, 8'h00, 8'h02);

        // Clear written on the exact tick that wraps 0xFF -> 0x00: set wins.
        apb_wr(8'h01, 8'h00);
        apb_wr(8'h00, 8'hFF);
        apb_wr(8'h01, 8'h80);
        apb_wr(8'h02, 8'h00);
        apb_rd(8'h02, 8'h00, "pre_simul_tsr");
        sync_to_13();
        apb_wr(8'h01, 8'h13);
        apb_rd(8'h03, 8'hFF, "simul_tcnt_loaded");
        sync_to_13();
        apb_wr(8'h02, 8'h00);
        apb_rd(8'h02, 8'h01, "simul_set_wins");
        apb_rd(8'h03, 8'h00, "simul_tcnt_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
